wb_rr_arbiter: RTL

Round-robin Wishbone bus arbiter that shares one pipelined Wishbone target port between ITR_CNT initiators. It sits in the WbXbc fabric in front of each target, downstream of the per-initiator address decoders, and runs on the system clock and resets distributed by the SYSCON block. Grants are held for a whole bus cycle (CYC) and passed on in round-robin order.

---
 rtl/wb_rr_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: ITR_CNT pipelined initiators share one target, grant held per CYC.
// Optional bus lock support is compiled in with `define WB_RR_ARB_LOCK_EN.
module wb_rr_arbiter #(
  parameter int ITR_CNT   = 4,
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 16,
  parameter int SEL_WIDTH = 2
) (
  input  logic                           clk_i,
  input  logic                           async_rst_i,
  input  logic                           sync_rst_i,
  input  logic [ITR_CNT-1:0]             itr_cyc_i,
  input  logic [ITR_CNT-1:0]             itr_stb_i,
  input  logic [ITR_CNT-1:0]             itr_we_i,
  input  logic [ITR_CNT*ADR_WIDTH-1:0]   itr_adr_i,
  input  logic [ITR_CNT*SEL_WIDTH-1:0]   itr_sel_i,
  input  logic [ITR_CNT*DAT_WIDTH-1:0]   itr_dat_i,
`ifdef WB_RR_ARB_LOCK_EN
  input  logic [ITR_CNT-1:0]             itr_lock_i,
`endif
  output logic [ITR_CNT-1:0]             itr_ack_o,
  output logic [ITR_CNT-1:0]             itr_err_o,
  output logic [ITR_CNT-1:0]             itr_rty_o,
  output logic [ITR_CNT-1:0]             itr_stall_o,
  output logic [DAT_WIDTH-1:0]           itr_dat_o,
  output logic                           tgt_cyc_o,
  output logic                           tgt_stb_o,
  output logic                           tgt_we_o,
  output logic [ADR_WIDTH-1:0]           tgt_adr_o,
  output logic [SEL_WIDTH-1:0]           tgt_sel_o,
  output logic [DAT_WIDTH-1:0]           tgt_dat_o,
  input  logic                           tgt_ack_i,
  input  logic                           tgt_err_i,
  input  logic                           tgt_rty_i,
  input  logic                           tgt_stall_i,
  input  logic [DAT_WIDTH-1:0]           tgt_dat_i
);

  localparam int PTR_W = (ITR_CNT > 1) ? $clog2(ITR_CNT) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(ITR_CNT - 1);
  localparam logic [ITR_CNT-1:0] ONE_HOT0 = {{(ITR_CNT-1){1'b0}}, 1'b1};

  logic [ITR_CNT-1:0]   r_gnt;
  logic [PTR_W-1:0]     r_ptr;
  logic                 w_release;
  logic                 w_found;
  logic [PTR_W-1:0]     w_win;
  logic [ADR_WIDTH-1:0] w_adr;
  logic [SEL_WIDTH-1:0] w_sel;
  logic [DAT_WIDTH-1:0] w_dat;

  // A locked owner keeps the bus across a CYC gap until it also drops its lock.
`ifdef WB_RR_ARB_LOCK_EN
  assign w_release = ~|(r_gnt & (itr_cyc_i | itr_lock_i));
`else
  assign w_release = ~|(r_gnt & itr_cyc_i);
`endif

  // Search requesters starting just after the last winner, wrapping modulo ITR_CNT.
  always_comb begin : p_search
    int w_idx;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int off = 1; off <= ITR_CNT; off++) begin
      w_idx = (int'(r_ptr) + off) % ITR_CNT;
      if (!w_found && itr_cyc_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = PTR_W'(w_idx);
      end else begin
        w_found = w_found;
      end
    end
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      r_gnt <= '0;
      r_ptr <= PTR_RST;
    end else if (sync_rst_i) begin
      r_gnt <= '0;
      r_ptr <= PTR_RST;
    end else if (w_release) begin
      if (w_found) begin
        r_gnt <= ONE_HOT0 << w_win;
        r_ptr <= w_win;
      end else begin
        r_gnt <= '0;
        r_ptr <= r_ptr;
      end
    end else begin
      r_gnt <= r_gnt;
      r_ptr <= r_ptr;
    end
  end

  // One-hot AND-OR mux; all-zero grant yields zero payload.
  always_comb begin
    w_adr = '0;
    w_sel = '0;
    w_dat = '0;
    for (int i = 0; i < ITR_CNT; i++) begin
      w_adr = w_adr | (itr_adr_i[i*ADR_WIDTH +: ADR_WIDTH] & {ADR_WIDTH{r_gnt[i]}});
      w_sel = w_sel | (itr_sel_i[i*SEL_WIDTH +: SEL_WIDTH] & {SEL_WIDTH{r_gnt[i]}});
      w_dat = w_dat | (itr_dat_i[i*DAT_WIDTH +: DAT_WIDTH] & {DAT_WIDTH{r_gnt[i]}});
    end
  end

  assign tgt_cyc_o = |(itr_cyc_i & r_gnt);
  assign tgt_stb_o = |(itr_stb_i & r_gnt);
  assign tgt_we_o  = |(itr_we_i & r_gnt);
  assign tgt_adr_o = w_adr;
  assign tgt_sel_o = w_sel;
  assign tgt_dat_o = w_dat;

  assign itr_ack_o   = {ITR_CNT{tgt_ack_i}} & r_gnt & itr_cyc_i;
  assign itr_err_o   = {ITR_CNT{tgt_err_i}} & r_gnt & itr_cyc_i;
  assign itr_rty_o   = {ITR_CNT{tgt_rty_i}} & r_gnt & itr_cyc_i;
  assign itr_stall_o = ~r_gnt | {ITR_CNT{tgt_stall_i}};
  assign itr_dat_o   = tgt_dat_i;

endmodule
